// File: rtl/fv_enc_pkg.sv
// Shared definitions for the FV encryption datapath: default modulus,
// coefficient/error sample types and the index-width helper.
package fv_enc_pkg;

    localparam int QW_DEFAULT = 64;
    localparam int EW_DEFAULT = 8;
    localparam int N_DEFAULT  = 16;

    // Default ciphertext modulus, the largest 64-bit prime.
    localparam logic [QW_DEFAULT-1:0] FV_Q_DEFAULT = 64'hFFFF_FFFF_FFFF_FFC5;

    typedef logic [QW_DEFAULT-1:0]        coeff_t;
    typedef logic signed [EW_DEFAULT-1:0] err_t;

    // Width of a counter that walks 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fv_coeff_mod_add_if.sv
// Stream bundle for the "+e" modular-add stage: product stream in,
// error-sample stream in, reduced coefficient stream out, framing status.
interface fv_coeff_mod_add_if
    import fv_enc_pkg::*;
#(
    parameter int QW = QW_DEFAULT,
    parameter int EW = EW_DEFAULT
);

    logic                 prod_valid;
    logic                 prod_ready;
    logic [QW-1:0]        prod_data;
    logic                 prod_last;
    logic                 err_valid;
    logic                 err_ready;
    logic signed [EW-1:0] err_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [QW-1:0]        out_data;
    logic                 out_last;
    logic                 frame_done;
    logic                 frame_err;

    // Environment side: drives the two input streams and the downstream ready.
    modport master (
        output prod_valid, prod_data, prod_last,
        output err_valid, err_data,
        output out_ready,
        input  prod_ready, err_ready,
        input  out_valid, out_data, out_last,
        input  frame_done, frame_err
    );

    // Stage side: the modular-add block itself.
    modport slave (
        input  prod_valid, prod_data, prod_last,
        input  err_valid, err_data,
        input  out_ready,
        output prod_ready, err_ready,
        output out_valid, out_data, out_last,
        output frame_done, frame_err
    );

endinterface

// File: rtl/fv_mod_corr.sv
// Single conditional correction of a small signed sum back into [0,q).
// The sum is assumed to lie in (-q, 2q), which holds whenever one operand
// is already reduced and the other is smaller in magnitude than q.
module fv_mod_corr #(
    parameter int QW = 64
) (
    input  logic signed [QW+1:0] sum,
    input  logic [QW-1:0]        q,
    output logic [QW-1:0]        result
);

    logic signed [QW+1:0] q_ext;
    logic signed [QW+1:0] corr_full;
    logic                 unused_corr_hi;

    assign q_ext = $signed({2'b00, q});

    // Add q to negative sums, subtract q from sums at or above q.
    always_comb begin
        corr_full = sum;
        if (sum[QW+1]) begin
            corr_full = sum + q_ext;
        end else if (sum >= q_ext) begin
            corr_full = sum - q_ext;
        end
    end

    assign result         = corr_full[QW-1:0];
    assign unused_corr_hi = ^corr_full[QW+1:QW];

endmodule

// File: rtl/fv_coeff_mod_add.sv
// FV "+e" stage: c_i = (prod_i + e_i) mod Q, two-stage valid/ready pipeline
// with frame tracking. Optional feature macro: FV_MOD_ADD_FRAME_CHECK_EN
// (checks upstream prod_last against the local index and flags frame_err).
module fv_coeff_mod_add
    import fv_enc_pkg::*;
#(
    parameter int            N  = N_DEFAULT,
    parameter int            QW = QW_DEFAULT,
    parameter int            EW = EW_DEFAULT,
    parameter logic [QW-1:0] Q  = FV_Q_DEFAULT[QW-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    fv_coeff_mod_add_if.slave bus
);

    localparam int IDX_W = idx_w(N);
    localparam int SW    = QW + 2;

    logic                 s1_valid_q, s1_valid_d;
    logic signed [SW-1:0] s1_sum_q,   s1_sum_d;
    logic                 s1_last_q,  s1_last_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [QW-1:0]        s2_data_q,  s2_data_d;
    logic                 s2_last_q,  s2_last_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic                 frame_done_q, frame_done_d;

    logic                 s1_ready;
    logic                 s2_ready;
    logic                 in_fire;
    logic                 out_fire;
    logic                 is_last_idx;
    logic signed [SW-1:0] sum_in;
    logic [QW-1:0]        corr_result;

    // Handshake: both input streams join into stage 1; readies come only from downstream occupancy.
    always_comb begin
        s2_ready    = ~s2_valid_q | bus.out_ready;
        s1_ready    = ~rst & (~s1_valid_q | s2_ready);
        in_fire     = bus.prod_valid & bus.err_valid & s1_ready;
        out_fire    = s2_valid_q & bus.out_ready;
        is_last_idx = (idx_q == IDX_W'(N - 1));
    end

    assign bus.prod_ready = bus.err_valid & s1_ready;
    assign bus.err_ready  = bus.prod_valid & s1_ready;

    // Wide signed sum leaves room for both a negative result and a carry past Q.
    assign sum_in = $signed({2'b00, bus.prod_data})
                  + $signed({{(SW - EW){bus.err_data[EW-1]}}, bus.err_data});

    fv_mod_corr #(
        .QW (QW)
    ) u_corr (
        .sum    (s1_sum_q),
        .q      (Q),
        .result (corr_result)
    );

    // Next-state: stages load when their downstream slot frees, otherwise hold.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sum_d     = s1_sum_q;
        s1_last_d    = s1_last_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_last_d    = s2_last_q;
        idx_d        = idx_q;
        frame_done_d = out_fire & s2_last_q;

        if (s1_ready) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                s1_sum_d  = sum_in;
                s1_last_d = is_last_idx;
            end
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = corr_result;
                s2_last_d = s1_last_q;
            end
        end

        if (in_fire) begin
            idx_d = is_last_idx ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Pipeline, index and frame_done registers; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_last_q    <= 1'b0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_q     <= s1_sum_d;
            s1_last_q    <= s1_last_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_last_q    <= s2_last_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.out_data   = s2_data_q;
    assign bus.out_last   = s2_last_q;
    assign bus.frame_done = frame_done_q;

`ifdef FV_MOD_ADD_FRAME_CHECK_EN
    logic frame_err_q, frame_err_d;

    // Any accepted beat whose upstream last flag disagrees with the local index latches an error.
    always_comb begin
        frame_err_d = frame_err_q | (in_fire & (bus.prod_last != is_last_idx));
    end

    // Sticky framing error, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    logic unused_prod_last;

    assign unused_prod_last = bus.prod_last;
    assign bus.frame_err    = 1'b0;
`endif

endmodule

// File: doc/fv_coeff_mod_add.md
Name: fv_coeff_mod_add

Overview:
- Streaming stage directly downstream of multiplier_syntop.
- Consumes the product polynomial coefficient stream (each coefficient in [0,Q)) and a parallel signed error-sample stream.
- Outputs c_i = (prod_i + e_i) mod Q, one coefficient per cycle, framed in polynomials of N coefficients; this is the "+e" step of FV encryption.
- Two-stage valid/ready pipeline with full backpressure and frame tracking.

Parameters:
- N, 16: coefficients per polynomial (power of two, ≥2).
- QW, 64: coefficient bit-width.
- EW, 8: error-sample bit-width, two's complement; 2^(EW-1) < Q is required.
- Q, 64'hFFFF_FFFF_FFFF_FFC5: modulus, QW bits wide, Q > 2^(EW-1), Q < 2^QW.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- prod_valid  in  1  product coefficient valid.
- prod_ready  out  1  product coefficient accepted.
- prod_data  in  QW  product coefficient, 0 ≤ prod_data < Q.
- prod_last  in  1  upstream marks final coefficient of a polynomial.
- err_valid  in  1  error sample valid.
- err_ready  out  1  error sample accepted.
- err_data  in  EW  signed error sample.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  QW  (prod+err) mod Q.
- out_last  out  1  result is coefficient N-1 of its polynomial.
- frame_done  out  1  one-cycle pulse when an out_last beat is accepted.
- frame_err  out  1  sticky framing error (see Optional Feature).

Behaviour:
- **Reset:** all outputs and internal valids, the index counter and frame_err go to 0 immediately on rst high. Reset mid-frame discards in-flight data; the next accepted beat is index 0.
- **Join rule:**
  - Input fires when prod_valid & err_valid & s1_ready.
  - prod_ready = err_valid & s1_ready; err_ready = prod_valid & s1_ready.
  - Neither stream is consumed alone. Ready does not depend on its own valid.
- **Pipeline advance:**
  - s2_ready = ~s2_valid | out_ready.
  - s1_ready = ~s1_valid | s2_ready.
  - A stage with valid set holds its data while stalled.
- **Stage 1:** sum = zero-extended prod_data + sign-extended err_data, held as a (QW+2)-bit signed value. Also registers idx==N-1 as last.
- **Stage 2 correction:**
  - sum<0 → sum+Q.
  - sum≥Q → sum−Q.
  - otherwise → sum.
  - Result is truncated to QW bits and is always in [0,Q).
- **Latency and throughput:** 2 cycles from input fire to out_valid when unstalled; throughput 1 coefficient per cycle with out_ready held high.
- **Index counter:**
  - log2(N) bits, increments on every input fire, wraps N-1 → 0.
  - out_last is derived from the counter only; prod_last never drives out_last.
- **frame_done:** registered; asserts the cycle after out_valid & out_ready & out_last.
- **Simultaneous fill and drain:** input fire and output fire in the same cycle with both stages full gives no bubble and no loss.
- **Boundary rule:** prod_data ≥ Q is out of contract; out_data is undefined in that case but the handshake stays correct.

Optional Feature:
- Macro: FV_MOD_ADD_FRAME_CHECK_EN.
- When defined: on every input fire, compare prod_last with (idx==N-1). Any mismatch sets frame_err, which stays high until rst. Data flow is unaffected.
- When undefined: prod_last is ignored and frame_err is tied to 0.

Decomposition:
- fv_enc_pkg holds:
  - default Q constant FV_Q_DEFAULT;
  - typedef coeff_t (logic [QW-1:0]);
  - typedef err_t (logic signed [EW-1:0]);
  - function clog2-based IDX_W.
- Sub-module fv_mod_corr: combinational stage-2 correction (sum, Q → result). It is reused later by the c1 path.

Test Plan (bench config: QW=8, Q=97, EW=4, N=16):
- prod=96, err=+3 → out_data=2, 2 cycles after fire.
- prod=0, err=−1 → out_data=96; prod=50, err=0 → 50; prod=96, err=−8 → 88.
- 16 back-to-back beats with out_ready=1 → 16 consecutive out_valid; out_last only on beat 16; frame_done pulses once the cycle after.
- out_ready low for 5 cycles mid-frame with inputs valid → prod_ready/err_ready drop after 2 buffered beats; no beat lost or duplicated; order preserved.
- err_valid low while prod_valid high → prod_ready=0, nothing consumed; raise err_valid → single fire.
- With FV_MOD_ADD_FRAME_CHECK_EN: prod_last=1 on beat 5 → frame_err=1 and stays high. Then assert rst after 7 beats → all outputs 0, frame_err=0, and the next frame's out_last lands on beat 16.
